// File: rtl/baud_tick_gen.sv
// Programmable baud-rate divider: one-cycle tick plus a divided square clock.
// Optional fractional divide (average period D + frac/256) when BAUD_FRAC_EN is defined.
module baud_tick_gen #(
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 868
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] div_value,
   input  logic                 div_load,
`ifdef BAUD_FRAC_EN
   input  logic [7:0]           frac,
`endif
   output logic                 tick,
   output logic                 divided_clock,
   output logic [CNT_WIDTH-1:0] cur_div
);

   localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(2);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] div_reg;
   logic [CNT_WIDTH-1:0] counter;
   logic [CNT_WIDTH-1:0] term_cnt;
   logic [CNT_WIDTH-1:0] half_m1;
   logic [CNT_WIDTH-1:0] load_div;
   logic                 period_end;
   logic                 extend;

`ifdef BAUD_FRAC_EN
   logic [7:0] frac_reg;
   // Bit 8 holds the carry of the last accumulation: it stretches the current period by one.
   logic [8:0] frac_acc;

   assign extend = frac_acc[8];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frac_reg <= 8'd0;
         frac_acc <= 9'd0;
      end else if (div_load) begin
         frac_reg <= frac;
         frac_acc <= 9'd0;
      end else if (enable && period_end) begin
         frac_acc <= {1'b0, frac_acc[7:0]} + {1'b0, frac_reg};
      end
   end
`else
   assign extend = 1'b0;
`endif

   assign load_div   = (div_value < MIN_DIV) ? MIN_DIV : div_value;
   assign term_cnt   = div_reg - ONE + {{(CNT_WIDTH-1){1'b0}}, extend};
   assign half_m1    = (div_reg >> 1) - ONE;
   assign period_end = (counter == term_cnt);
   assign cur_div    = div_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_reg       <= DEF_DIV;
         counter       <= '0;
         tick          <= 1'b0;
         divided_clock <= 1'b0;
      end else if (div_load) begin
         div_reg       <= load_div;
         counter       <= '0;
         tick          <= 1'b0;
         divided_clock <= 1'b0;
      end else if (enable) begin
         if (period_end) begin
            counter       <= '0;
            tick          <= 1'b1;
            divided_clock <= 1'b0;
         end else begin
            counter <= counter + ONE;
            tick    <= 1'b0;
            if (counter == half_m1)
               divided_clock <= 1'b1;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Randomized + directed bench for baud_tick_gen against a phase-counting reference model.
module tb_baud_tick_gen;

   localparam int W   = 16;
   localparam int DEF = 868;

   logic         clock     = 1'b0;
   logic         reset_n   = 1'b0;
   logic         enable    = 1'b0;
   logic         div_load  = 1'b0;
   logic [W-1:0] div_value = '0;
   logic [7:0]   frac      = 8'd0;
   logic         tick;
   logic         divided_clock;
   logic [W-1:0] cur_div;

   always #5 clock = ~clock;

   baud_tick_gen #(.CNT_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .div_value     (div_value),
      .div_load      (div_load),
`ifdef BAUD_FRAC_EN
      .frac          (frac),
`endif
      .tick          (tick),
      .divided_clock (divided_clock),
      .cur_div       (cur_div)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: phase = enabled edges since period start; period = D (+1 after a carry).
   int m_div, m_period, m_phase, m_acc, m_frac;
   bit m_tick, m_dc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_div = DEF; m_period = DEF; m_phase = 0; m_tick = 0; m_dc = 0;
      m_frac = 0; m_acc = 0;
   endtask

   task automatic m_edge();
      if (div_load) begin
         m_div    = (int'(div_value) < 2) ? 2 : int'(div_value);
         m_period = m_div; m_phase = 0; m_tick = 0; m_dc = 0; m_acc = 0;
`ifdef BAUD_FRAC_EN
         m_frac = int'(frac);
`endif
      end else if (enable) begin
         m_phase++;
         if (m_phase == m_period) begin
            m_tick = 1; m_dc = 0; m_phase = 0;
            m_acc += m_frac;
            if (m_acc >= 256) begin
               m_acc -= 256;
               m_period = m_div + 1;
            end else begin
               m_period = m_div;
            end
         end else begin
            m_tick = 0;
            m_dc   = (m_phase >= m_div / 2);
         end
      end else begin
         m_tick = 0;
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (reset_n) m_edge(); else m_reset();
      check("tick", {31'd0, tick}, {31'd0, m_tick});
      check("dclk", {31'd0, divided_clock}, {31'd0, m_dc});
      check("cur_div", {16'd0, cur_div}, m_div);
   endtask

   task automatic run_until_tick(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic load(input int d, input int f);
      div_value = W'(d);
      frac      = 8'(f);
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
   endtask

   int n, span;

   initial begin
      m_reset();
      step();
      step();
      check("rst_cur_div", {16'd0, cur_div}, DEF);
      reset_n = 1'b1;
      enable  = 1'b1;

      // Default divisor: first tick on edge 868, then every 868.
      run_until_tick(2000, n);
      check("t1_first", n, DEF);
      run_until_tick(2000, n);
      check("t1_period", n, DEF);

      // D=5: low 2 / high 3, tick coincides with falling divided_clock.
      load(5, 0);
      run_until_tick(20, n);
      check("t2_first", n, 5);
      run_until_tick(20, n);
      check("t2_period", n, 5);

      // Clamping of 0 and 1.
      load(0, 0);
      check("t3_clamp0", {16'd0, cur_div}, 2);
      run_until_tick(10, n);
      check("t3_period0", n, 2);
      load(1, 0);
      check("t3_clamp1", {16'd0, cur_div}, 2);
      for (int i = 0; i < 6; i++) step();

      // Freeze 7 cycles mid-count: tick arrives 7 cycles late.
      load(10, 0);
      for (int i = 0; i < 4; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 7; i++) step();
      enable = 1'b1;
      run_until_tick(40, n);
      check("t4_frozen", n + 11, 17);

      // Load at a period end with enable high: load wins, no tick.
      load(6, 0);
      for (int i = 0; i < 5; i++) step();
      div_value = W'(7);
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
      check("load_prio_tick", {31'd0, tick}, 0);
      check("load_prio_div", {16'd0, cur_div}, 7);

      // Asynchronous reset while divided_clock is high.
      load(5, 0);
      step();
      step();
      check("t5_dclk_pre", {31'd0, divided_clock}, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_tick", {31'd0, tick}, 0);
      check("t5_dclk", {31'd0, divided_clock}, 0);
      check("t5_cur_div", {16'd0, cur_div}, DEF);
      m_reset();
      #2 reset_n = 1'b1;
      step();

`ifdef BAUD_FRAC_EN
      // Fractional: periods 10,10,11,10,11...; 256 periods after the first tick span 2688.
      load(10, 128);
      run_until_tick(20, n);
      check("t6_p1", n, 10);
      span = 0;
      for (int k = 0; k < 256; k++) begin
         run_until_tick(20, n);
         if (k == 0) check("t6_p2", n, 10);
         if (k == 1) check("t6_p3", n, 11);
         if (n < 0) begin
            check("t6_timeout", n, 10);
            break;
         end
         span += n;
      end
      check("t6_span", span, 2688);
`endif

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         enable    = ($urandom_range(0, 9) < 8);
         div_load  = ($urandom_range(0, 99) < 3);
         div_value = W'($urandom_range(0, 12));
         frac      = 8'($urandom_range(0, 255));
         step();
      end
      div_load = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
